// File: rtl/client_tx_u.sv
// Status-packet client: measures three clocks against clk, samples board pins and
// offers a fixed 16-byte report to the transmit port through a req/ack/strobe handshake.

// Free-running Gray counter in the measured domain, synchronised into clk.
// Outputs the number of measured edges since the previous wrap.
module client_tx_u_meter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        meas_clk,
    input  logic        wrap,
    output logic [15:0] count
);
    logic [15:0] bin_cnt;
    logic [15:0] gray_cnt;
    logic [15:0] bin_next;
    logic [15:0] sync1;
    logic [15:0] sync2;
    logic [15:0] cur;
    logic [15:0] prev;

    function automatic logic [15:0] gray_to_bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin_next = bin_cnt + 16'd1;

    // Only one bit changes per edge, so a sample taken mid-transition is off by at most one.
    always_ff @(posedge meas_clk) begin
        bin_cnt  <= bin_next;
        gray_cnt <= bin_next ^ (bin_next >> 1);
    end

    always_ff @(posedge clk) begin
        sync1 <= gray_cnt;
        sync2 <= sync1;
        cur   <= gray_to_bin(sync2);
        if (!rst_n) begin
            prev <= 16'd0;
        end else if (wrap) begin
            prev <= cur;
        end
    end

    assign count = cur - prev;
endmodule

module client_tx_u #(
    parameter int jumbo_dw     = 14,
    parameter int tck_mask     = 3,
    parameter int REFCNT_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                req,
    input  logic                ack,
    input  logic                strobe,
    output logic [jumbo_dw-1:0] length,
    output logic [7:0]          data_out,
    input  logic [7:0]          if_config,
    input  logic [31:0]         other,
    input  logic                rx_clk,
    input  logic                tx_clk,
    input  logic                gr_clk,
    output logic                GBE_FP_MDC,
    output logic                GBE_AX_MDC,
    inout  wire                 GBE_FP_MDIO,
    inout  wire                 GBE_AX_MDIO,
    inout  wire                 SFP0_MOD1,
    inout  wire                 SFP0_MOD2,
    inout  wire                 SFP1_MOD1,
    inout  wire                 SFP1_MOD2
);
    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t                  state;
    logic [REFCNT_WIDTH-1:0] ref_cnt;
    logic                    wrap;
    logic [15:0]             win_cnt;
    logic [15:0]             win_next;
    logic [tck_mask:0]       mdc_cnt;
    logic [5:0]              pin_s1;
    logic [5:0]              pin_s2;
    logic [7:0]              pins_byte;
    logic [7:0]              pkt [16];
    logic [4:0]              idx;
    logic [7:0]              seq;
    logic [15:0]             rx_count;
    logic [15:0]             tx_count;
    logic [15:0]             gr_count;

    client_tx_u_meter u_rx (.clk(clk), .rst_n(rst_n), .meas_clk(rx_clk), .wrap(wrap), .count(rx_count));
    client_tx_u_meter u_tx (.clk(clk), .rst_n(rst_n), .meas_clk(tx_clk), .wrap(wrap), .count(tx_count));
    client_tx_u_meter u_gr (.clk(clk), .rst_n(rst_n), .meas_clk(gr_clk), .wrap(wrap), .count(gr_count));

    assign wrap      = &ref_cnt;
    assign win_next  = win_cnt + 16'd1;
    assign length    = jumbo_dw'(16);
    assign pins_byte = {pin_s2[5], pin_s2[4], 2'b00, pin_s2[3:0]};

    assign GBE_FP_MDC = mdc_cnt[tck_mask];
    assign GBE_AX_MDC = mdc_cnt[tck_mask];

    // MDIO and SFP pins are never driven here; they are only sampled.
    always_ff @(posedge clk) begin
        pin_s1 <= {GBE_AX_MDIO, GBE_FP_MDIO, SFP1_MOD2, SFP1_MOD1, SFP0_MOD2, SFP0_MOD1};
        pin_s2 <= pin_s1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            win_cnt <= 16'd0;
            mdc_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            mdc_cnt <= mdc_cnt + 1'b1;
            if (wrap) begin
                win_cnt <= win_next;
            end
        end
    end

    // A wrap that arrives while a packet is pending or in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            data_out <= 8'h00;
            idx      <= 5'd0;
            seq      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    data_out <= 8'h00;
                    if (wrap) begin
                        pkt[0]  <= if_config;
                        pkt[1]  <= pins_byte;
                        pkt[2]  <= seq;
                        pkt[3]  <= 8'h00;
                        pkt[4]  <= rx_count[15:8];
                        pkt[5]  <= rx_count[7:0];
                        pkt[6]  <= tx_count[15:8];
                        pkt[7]  <= tx_count[7:0];
                        pkt[8]  <= gr_count[15:8];
                        pkt[9]  <= gr_count[7:0];
                        pkt[10] <= other[31:24];
                        pkt[11] <= other[23:16];
                        pkt[12] <= other[15:8];
                        pkt[13] <= other[7:0];
                        pkt[14] <= win_next[15:8];
                        pkt[15] <= win_next[7:0];
                        req     <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        req      <= 1'b0;
                        idx      <= 5'd0;
                        data_out <= pkt[0];
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (strobe) begin
                        if (idx == 5'd15) begin
                            idx      <= 5'd16;
                            data_out <= 8'h00;
                            seq      <= seq + 8'd1;
                            state    <= IDLE;
                        end else begin
                            idx      <= idx + 5'd1;
                            data_out <= pkt[idx[3:0] + 4'd1];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_client_tx_u.sv
// Self-checking bench for client_tx_u: a packet-level model predicts snapshot timing,
// contents, sequence and window numbering while randomized handshakes drive the port.
`timescale 1ns/1ps

module tb_client_tx_u;
    localparam int WIN = 4096;

    logic        clk = 1'b0;
    logic        rx_clk = 1'b0;
    logic        tx_clk = 1'b0;
    logic        gr_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack = 1'b0;
    logic        strobe = 1'b0;
    logic [7:0]  if_config = 8'h13;
    logic [31:0] other = 32'hDEADBEEF;
    logic        pin_fp = 1'b1;
    logic        pin_ax = 1'b1;
    logic        pin_s0m1 = 1'b1;
    logic        pin_s0m2 = 1'b1;
    logic        pin_s1m1 = 1'b1;
    logic        pin_s1m2 = 1'b1;

    wire         fp_mdio_w;
    wire         ax_mdio_w;
    wire         s0m1_w;
    wire         s0m2_w;
    wire         s1m1_w;
    wire         s1m2_w;
    assign fp_mdio_w = pin_fp;
    assign ax_mdio_w = pin_ax;
    assign s0m1_w    = pin_s0m1;
    assign s0m2_w    = pin_s0m2;
    assign s1m1_w    = pin_s1m1;
    assign s1m2_w    = pin_s1m2;

    logic        req;
    logic [13:0] length;
    logic [7:0]  data_out;
    logic        fp_mdc;
    logic        ax_mdc;

    int checks = 0;
    int errors = 0;

    client_tx_u dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .strobe(strobe),
        .length(length), .data_out(data_out), .if_config(if_config), .other(other),
        .rx_clk(rx_clk), .tx_clk(tx_clk), .gr_clk(gr_clk),
        .GBE_FP_MDC(fp_mdc), .GBE_AX_MDC(ax_mdc),
        .GBE_FP_MDIO(fp_mdio_w), .GBE_AX_MDIO(ax_mdio_w),
        .SFP0_MOD1(s0m1_w), .SFP0_MOD2(s0m2_w), .SFP1_MOD1(s1m1_w), .SFP1_MOD2(s1m2_w)
    );

    always #4 clk = ~clk;
    always #11 rx_clk = ~rx_clk;
    always #13 tx_clk = ~tx_clk;
    always #3 gr_clk = ~gr_clk;

    // Packet-level model: counts cycles since reset, accepts a snapshot on every
    // window boundary when no packet is outstanding, retires after 16 strobes.
    int cyc = 0;
    int wraps = 0;
    int seq_m = 0;
    bit busy = 0;
    bit sending = 0;
    int sent = 0;
    int accept_cyc = -1;
    int snap_cfg, snap_pins, snap_other, snap_win, snap_seq;

    always @(posedge clk) begin
        bit old_busy;
        if (!rst_n) begin
            cyc = 0; wraps = 0; seq_m = 0; busy = 0; sending = 0; sent = 0;
        end else begin
            cyc++;
            old_busy = busy;
            if (sending && strobe) begin
                sent++;
                if (sent == 16) begin
                    sending = 0;
                    busy = 0;
                    seq_m = (seq_m + 1) % 256;
                end
            end else if (busy && !sending && ack) begin
                sending = 1;
                sent = 0;
            end
            if (cyc % WIN == 0) begin
                wraps++;
                if (!old_busy) begin
                    busy = 1;
                    accept_cyc = cyc;
                    snap_cfg = int'(if_config);
                    snap_pins = int'({pin_ax, pin_fp, 2'b00, pin_s1m2, pin_s1m1, pin_s0m2, pin_s0m1});
                    snap_other = int'(other);
                    snap_win = wraps % 65536;
                    snap_seq = seq_m;
                end
            end
        end
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert ((observed >= lo) && (observed <= hi)) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Waits for one request, acknowledges it and consumes the packet with random gaps.
    task automatic apply_stimulus(input int ack_delay, input bit counts_valid, input bit reset_at7,
                                  input bit new_values, input int extra, output int win_f, output int seq_f);
        int budget;
        int e_cfg, e_pins, e_other, e_win, e_seq, e_acc;
        logic [7:0] got [16];
        win_f = -1;
        seq_f = -1;
        budget = 3 * WIN;
        while (req !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output("req_seen", int'(req), 1);
        if (req !== 1'b1) return;
        check_output("req_rise_cycle", cyc, accept_cyc);
        e_cfg = snap_cfg; e_pins = snap_pins; e_other = snap_other;
        e_win = snap_win; e_seq = snap_seq; e_acc = accept_cyc;
        repeat (ack_delay) @(negedge clk);
        if (ack_delay > 0) check_output("req_hold", int'(req), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_output("req_drop", int'(req), 0);
        check_output("length", int'(length), 16);
        if (new_values) begin
            if_config = 8'($urandom);
            other = $urandom;
            {pin_fp, pin_ax, pin_s0m1, pin_s0m2, pin_s1m1, pin_s1m2} = 6'($urandom);
        end
        for (int i = 0; i < 16; i++) begin
            if (reset_at7 && i == 7) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_output("reset_req", int'(req), 0);
                check_output("reset_data", int'(data_out), 0);
                strobe = 1'b1;
                @(negedge clk);
                strobe = 1'b0;
                check_output("strobe_after_reset", int'(data_out), 0);
                return;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            got[i] = data_out;
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
        end
        check_output("after_16th", int'(data_out), 0);
        for (int k = 0; k < extra; k++) begin
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
            check_output("extra_strobe", int'(data_out), 0);
        end
        check_output("byte0_cfg", int'(got[0]), e_cfg);
        check_output("byte1_pins", int'(got[1]), e_pins);
        check_output("byte2_seq", int'(got[2]), e_seq);
        check_output("byte3_zero", int'(got[3]), 0);
        check_output("other", int'({got[10], got[11], got[12], got[13]}), e_other);
        check_output("window", int'({got[14], got[15]}), e_win);
        if (counts_valid) begin
            check_range("rx_count", int'({got[4], got[5]}), 1487, 1491);
            check_range("tx_count", int'({got[6], got[7]}), 1258, 1262);
            check_range("gr_count", int'({got[8], got[9]}), 5459, 5463);
        end
        win_f = int'({got[14], got[15]});
        seq_f = int'(got[2]);
        $display("[TB] packet seq=%0d win=%0d accepted at cycle %0d", seq_f, win_f, e_acc);
    endtask

    initial begin
        int w1, s1, w2, s2, w3, s3, w4, s4, w5, s5, w6, s6, w7, s7;
        repeat (3) @(negedge clk);
        check_output("reset_req", int'(req), 0);
        check_output("reset_data", int'(data_out), 0);
        check_output("reset_length", int'(length), 16);
        check_output("reset_mdc", int'(fp_mdc), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_output("mdc_fp", int'(fp_mdc), ((cyc % 16) >= 8) ? 1 : 0);
            check_output("mdc_ax", int'(ax_mdc), ((cyc % 16) >= 8) ? 1 : 0);
        end
        strobe = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        ack = 1'b0;
        check_output("idle_ignore_req", int'(req), 0);
        check_output("idle_ignore_data", int'(data_out), 0);

        apply_stimulus($urandom_range(0, 5), 1'b0, 1'b0, 1'b0, 1, w1, s1);
        check_output("first_win", w1, 1);
        check_output("first_seq", s1, 0);
        apply_stimulus($urandom_range(0, 5), 1'b1, 1'b0, 1'b1, 1, w2, s2);
        check_output("seq_step2", s2, 1);
        apply_stimulus($urandom_range(0, 20), 1'b1, 1'b0, 1'b1, 3, w3, s3);
        check_output("seq_step3", s3, 2);
        apply_stimulus(5000, 1'b1, 1'b0, 1'b0, 1, w4, s4);
        apply_stimulus($urandom_range(0, 5), 1'b1, 1'b0, 1'b1, 2, w5, s5);
        check_output("win_skip", w5, w4 + 2);
        check_output("seq_after_drop", s5, s4 + 1);
        apply_stimulus($urandom_range(0, 5), 1'b1, 1'b1, 1'b0, 0, w6, s6);
        apply_stimulus($urandom_range(0, 5), 1'b0, 1'b0, 1'b1, 1, w7, s7);
        check_output("seq_after_reset", s7, 0);
        check_output("win_after_reset", w7, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/client_tx_u.md
# client_tx_u

Status-packet client for the Ethernet packet transmitter. It measures the rx_clk, tx_clk and gr_clk frequencies against clk and samples board pins (SFP module-detect, MDIO). It packs these together with if_config and a 32-bit user word into a fixed 16-byte packet. It offers the packet to the transmit port through a req/ack/strobe handshake, and also drives a free-running MDC clock to both PHY management buses.

## Interface
- jumbo_dw, 14: width of length.
- tck_mask, 3: counter bit index used for MDC; MDC period is 2^(tck_mask+1) clk cycles.
- REFCNT_WIDTH, 12: measurement window is 2^REFCNT_WIDTH clk cycles. Must be ≤15.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all handshake logic.
- rst_n  in  1  synchronous active-low reset.
- req  out  1  packet-ready request to the tx port.
- ack  in  1  tx port accepts the request.
- strobe  in  1  tx port consumes data_out this cycle.
- length  out  jumbo_dw  packet length in bytes; constant 16.
- data_out  out  8  current packet byte.
- if_config  in  8  configuration byte, reported verbatim.
- other  in  32  user word, reported.
- rx_clk, tx_clk, gr_clk  in  1  clocks under measurement.
- GBE_FP_MDC, GBE_AX_MDC  out  1  MDC outputs.
- GBE_FP_MDIO, GBE_AX_MDIO  inout  1  always released (z); sampled only.
- SFP0_MOD1, SFP0_MOD2, SFP1_MOD1, SFP1_MOD2  inout  1  released (z); sampled only.

## Operation
- Frequency measurement:
  - Each measured clock runs a free-running 16-bit Gray counter in its own domain, with no reset.
  - Each counter is synchronized into clk with two flops and converted to binary.
  - A clk-domain window counter (REFCNT_WIDTH bits) wraps every 2^REFCNT_WIDTH cycles.
  - At each wrap, count = current sample minus previous sample (mod 2^16), latched as the rx/tx/gr result.
  - A 16-bit window counter increments at each wrap.
- Snapshot on each wrap: if no packet is pending or in progress, capture the following into the packet buffer and assert req:
  - if_config.
  - The pins byte {GBE_AX_MDIO, GBE_FP_MDIO, 2'b0, SFP1_MOD2, SFP1_MOD1, SFP0_MOD2, SFP0_MOD1}, all synchronized.
  - The sequence byte.
  - The three counts, other and the window count.
- If busy at a wrap, that snapshot is dropped; the sequence byte is not incremented.
- Packet layout (multi-byte fields big-endian):
  - byte 0: if_config
  - byte 1: pins
  - byte 2: sequence
  - byte 3: 0x00
  - bytes 4–5: rx count
  - bytes 6–7: tx count
  - bytes 8–9: gr count
  - bytes 10–13: other
  - bytes 14–15: window count
- Sequence increments by 1 after each packet is fully sent, wrapping 255→0.
- States:
  - IDLE → REQ at a snapshot.
  - REQ → SEND when ack is sampled high.
  - SEND → IDLE after 16 strobe cycles.
- MDC: GBE_FP_MDC = GBE_AX_MDC = bit tck_mask of a free-running clk counter.

## Timing
- req rises on the cycle after the window wrap. It stays high until ack is sampled high, then drops on the next cycle.
- length is constant 16 at all times. The packet buffer is stable from req assertion until return to IDLE.
- Byte index resets to 0 on ack. data_out is registered: byte 0 is valid from the cycle after ack.
- Each cycle with strobe=1 consumes the current byte; the next byte appears on the following cycle.
- strobe beyond the 16th byte (tolerated up to any count): data_out = 0x00 and the index saturates.
- strobe or ack while in IDLE is ignored.
- Reset (rst_n=0 at a clk edge) forces:
  - req=0, data_out=0x00, state IDLE.
  - Byte index, sequence, window counter and MDC counter to 0.
  - Previous samples cleared, so the first window's counts are undefined.
- Reset mid-packet abandons the packet; any further strobes read 0x00.
- CDC latency of the counts is 3 clk cycles; error is ±1 count.

## Test plan
- clk 125 MHz, rx 45.45 MHz, tx 38.46 MHz, gr 166.7 MHz, REFCNT_WIDTH=12, port with ack<=req and strobe for 16+1 cycles -> from the second packet on: rx count ≈1489±2, tx ≈1260±2, gr ≈5461±2.
- Same run -> byte 0 = 0x13, byte 1 = 0xCF with all pins pulled high, bytes 10–13 = DE AD BE EF, and the sequence increments 0,1,2… between packets.
- Hold ack low for 5000 cycles -> req stays high, the next wrap is dropped, and the window count in the eventual packet skips by 2.
- 17th and extra strobes -> data_out = 0x00; req rises again exactly at the next wrap.
- Assert rst_n=0 during SEND at byte 7 -> req=0, data_out=0x00 and sequence=0 the next cycle; the first packet after reset has sequence 0.
- Observe MDC with tck_mask=3 -> a 16-cycle period with 50% duty, identical on both MDC pins; MDIO and SFP pins stay z.
